// File: rtl/booth_controller.sv
// -----------------------------------------------------------------------------
// booth_controller
//
// Sequencing FSM for a radix-2 Booth multiplier datapath. It accepts an
// operand-load request over a valid/ready handshake, then steps the datapath
// through WIDTH iterations. Each iteration is an OP cycle (add/sub/none,
// chosen from the Booth pair {q0,q_m1}) followed by a SHIFT cycle. The
// finished product is then offered over a second valid/ready handshake.
//
// Ports
//   clk         in   clock, all state on the rising edge
//   reset       in   asynchronous active-low reset (0 = reset)
//   clear       in   synchronous abort back to IDLE (highest priority)
//   src_valid   in   operands valid at the datapath inputs
//   src_ready   out  controller can accept operands (IDLE only)
//   q0          in   LSB of the multiplier (Q) register
//   q_m1        in   Booth extension bit Q[-1]
//   load_en     out  load A=0, Q=multiplier, Q[-1]=0, M=multiplicand
//   add_en      out  A <= A + M
//   sub_en      out  A <= A - M
//   shift_en    out  arithmetic right shift of {A,Q,Q[-1]}
//   count       out  current iteration index (0..WIDTH-1, never wraps)
//   busy        out  high in every state except IDLE
//   dest_valid  out  product {A,Q} valid
//   dest_ready  in   consumer accepts the product
//
// Latency from the accepting clock edge to the first dest_valid cycle is
// 1 + 2*WIDTH edges regardless of the operand bit pattern.
// -----------------------------------------------------------------------------
module booth_controller #(
  parameter  int WIDTH = 16,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             src_valid,
  output logic             src_ready,
  input  logic             q0,
  input  logic             q_m1,
  output logic             load_en,
  output logic             add_en,
  output logic             sub_en,
  output logic             shift_en,
  output logic [CNT_W-1:0] count,
  output logic             busy,
  output logic             dest_valid,
  input  logic             dest_ready
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_OP,
    ST_SHIFT,
    ST_DONE
  } state_e;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;

  // ---------------------------------------------------------------------------
  // State and iteration counter registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch; blocking (=) is correct here.
    state_d    = state_q;
    count_d    = count_q;
    src_ready  = 1'b0;
    busy       = 1'b1;
    load_en    = 1'b0;
    add_en     = 1'b0;
    sub_en     = 1'b0;
    shift_en   = 1'b0;
    dest_valid = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        src_ready = 1'b1;
        busy      = 1'b0;
        if (src_valid) begin
          state_d = ST_LOAD;
        end
      end

      ST_LOAD: begin
        load_en = 1'b1;
        count_d = '0;
        state_d = ST_OP;
      end

      ST_OP: begin
        // The Booth pair is only looked at inside OP, so an unknown q0/q_m1
        // in any other state never reaches the strobes.
        if ({q0, q_m1} == 2'b10) begin
          sub_en = 1'b1;
        end else if ({q0, q_m1} == 2'b01) begin
          add_en = 1'b1;
        end
        state_d = ST_SHIFT;
      end

      ST_SHIFT: begin
        shift_en = 1'b1;
        if (count_q == LAST_ITER) begin
          // Final iteration: count parks at WIDTH-1 rather than wrapping.
          state_d = ST_DONE;
        end else begin
          count_d = count_q + CNT_W'(1);
          state_d = ST_OP;
        end
      end

      ST_DONE: begin
        dest_valid = 1'b1;
        if (dest_ready) begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      end

      default: begin
        busy    = 1'b0;
        state_d = ST_IDLE;
        count_d = '0;
      end
    endcase

    // Abort wins over every transition and suppresses the datapath strobes
    // for that cycle so the accumulator is left untouched.
    if (clear) begin
      state_d  = ST_IDLE;
      count_d  = '0;
      load_en  = 1'b0;
      add_en   = 1'b0;
      sub_en   = 1'b0;
      shift_en = 1'b0;
    end
  end

  assign count = count_q;

endmodule
